// File: rtl/id_operand_stage.sv
// Decode-stage operand front end: IF/ID register, instruction-word hold buffer
// for stalls against a synchronous SRAM, bypass-aware operand resolution,
// load-use interlock, ID-stage branch resolution and the ID/EX register.
module id_operand_stage #(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_id,
    input  logic                        stall_ex,
    input  logic                        flush,
    input  logic                        if_valid,
    input  logic [31:0]                 if_pc,
    input  logic [31:0]                 inst_rdata,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD-1:0]          fwd_is_load,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
    output logic [ADDR_W-1:0]           rf_raddr1,
    output logic [ADDR_W-1:0]           rf_raddr2,
    input  logic [DATA_W-1:0]           rf_rdata1,
    input  logic [DATA_W-1:0]           rf_rdata2,
    output logic                        stallreq,
    output logic                        br_e,
    output logic [31:0]                 br_addr,
    output logic                        ex_valid,
    output logic [31:0]                 ex_pc,
    output logic [31:0]                 ex_inst,
    output logic [DATA_W-1:0]           ex_src1,
    output logic [DATA_W-1:0]           ex_src2
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SWL     = 6'b101010;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_SWR     = 6'b101110;

    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_pc_q, id_pc_d;
    logic [31:0]       inst_hold_q, inst_hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [31:0]       ex_inst_q, ex_inst_d;
    logic [DATA_W-1:0] ex_src1_q, ex_src1_d;
    logic [DATA_W-1:0] ex_src2_q, ex_src2_d;

    logic [31:0]       id_inst;
    logic [5:0]        op;
    logic [15:0]       imm;
    logic [NUM_FWD-1:0] hit1, hit2;
    logic [DATA_W-1:0] src1, src2;
    logic              load1, load2;
    logic              rs_used, rt_used;
    logic              br_cond;
    logic              id_hold;

    // An invalid ID slot decodes as all-zero so nothing downstream sees stale SRAM data.
    assign id_inst   = id_valid_q ? (hold_vld_q ? inst_hold_q : inst_rdata) : 32'h0;
    assign op        = id_inst[31:26];
    assign imm       = id_inst[15:0];
    assign rf_raddr1 = ADDR_W'(id_inst[25:21]);
    assign rf_raddr2 = ADDR_W'(id_inst[20:16]);

    // Per-channel address match for both sources.
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_hit
            assign hit1[gi] = fwd_we[gi] && (fwd_waddr[gi*ADDR_W +: ADDR_W] == rf_raddr1);
            assign hit2[gi] = fwd_we[gi] && (fwd_waddr[gi*ADDR_W +: ADDR_W] == rf_raddr2);
        end
    endgenerate

    // Operand resolution: walk oldest to youngest so the lowest-index match wins; r0 is always zero.
    always_comb begin
        src1  = rf_rdata1;
        src2  = rf_rdata2;
        load1 = 1'b0;
        load2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                src1  = fwd_wdata[i*DATA_W +: DATA_W];
                load1 = fwd_is_load[i];
            end
            if (hit2[i]) begin
                src2  = fwd_wdata[i*DATA_W +: DATA_W];
                load2 = fwd_is_load[i];
            end
        end
        if (rf_raddr1 == '0) begin
            src1  = '0;
            load1 = 1'b0;
        end
        if (rf_raddr2 == '0) begin
            src2  = '0;
            load2 = 1'b0;
        end
    end

    // Which source fields the current opcode actually reads.
    always_comb begin
        rs_used = !((op == OP_LUI) || (op == OP_J) || (op == OP_JAL));
        rt_used = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
                  (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) ||
                  (op == OP_SW) || (op == OP_SWR);
    end

    assign stallreq = id_valid_q && ((rs_used && load1) || (rt_used && load2));

    // Branch resolution in ID; suppressed while the operands are still waiting on a load.
    always_comb begin
        br_cond = 1'b0;
        if (op == OP_BEQ) begin
            br_cond = (src1 == src2);
        end else if (op == OP_BNE) begin
            br_cond = (src1 != src2);
        end
        br_e    = id_valid_q && !stallreq && br_cond;
        br_addr = br_e ? (id_pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00}) : 32'h0;
    end

    // IF/ID next state, including capture of the SRAM word on the first held cycle.
    always_comb begin
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        inst_hold_d = inst_hold_q;
        hold_vld_d  = hold_vld_q;
        id_hold     = stall_id && stall_ex && !flush;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (stall_id && !stall_ex) begin
            id_valid_d = 1'b0;
        end else if (!stall_id) begin
            id_valid_d = if_valid;
            id_pc_d    = if_pc;
        end
        if (id_hold) begin
            if (id_valid_q && !hold_vld_q) begin
                inst_hold_d = inst_rdata;
                hold_vld_d  = 1'b1;
            end
        end else begin
            hold_vld_d = 1'b0;
        end
    end

    // ID/EX next state: flush beats hold, hold beats bubble, bubble beats load.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_inst_d  = ex_inst_q;
        ex_src1_d  = ex_src1_q;
        ex_src2_d  = ex_src2_q;
        if (flush || (!stall_ex && (stallreq || stall_id))) begin
            ex_valid_d = 1'b0;
            ex_pc_d    = 32'h0;
            ex_inst_d  = 32'h0;
            ex_src1_d  = '0;
            ex_src2_d  = '0;
        end else if (!stall_ex) begin
            ex_valid_d = id_valid_q;
            ex_pc_d    = id_pc_q;
            ex_inst_d  = id_inst;
            ex_src1_d  = src1;
            ex_src2_d  = src2;
        end
    end

    // Pipeline state registers; reset clears everything immediately, hold buffer included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'h0;
            inst_hold_q <= 32'h0;
            hold_vld_q  <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= 32'h0;
            ex_inst_q   <= 32'h0;
            ex_src1_q   <= '0;
            ex_src2_q   <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            inst_hold_q <= inst_hold_d;
            hold_vld_q  <= hold_vld_d;
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_inst_q   <= ex_inst_d;
            ex_src1_q   <= ex_src1_d;
            ex_src2_q   <= ex_src2_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_inst  = ex_inst_q;
    assign ex_src1  = ex_src1_q;
    assign ex_src2  = ex_src2_q;

endmodule
